// File: rtl/fetch_unit.sv
// fetch_unit: 16-bit byte-addressed instruction fetch stage with IF/ID register.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                hold PC and IF/ID register (RUN only)
//   redirect/redirect_pc branch/flush request and byte target
//   imem_addr/imem_rdata combinational instruction memory port
//   ifid_instr/pc/valid  registered fetch result
//   halted               high while the fetch FSM is in HALT
//   fetch_err            sticky out-of-range fetch flag
//   fetch_count          saturating count of valid instructions delivered
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_DEPTH = 27,
    parameter logic [15:0] HALT_WORD  = 16'hEBCF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        out_of_range;

    assign imem_addr    = pc_q;
    assign out_of_range = {1'b0, pc_q[15:1]} >= DEPTH16;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            // Redirect wins over HALT so a wrong-path halt is squashed.
            state_d = RUN;
            pc_d    = {redirect_pc[15:1], 1'b0};
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else if (state_q == HALT) begin
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else if (stall) begin
            state_d = RUN;
        end else if (out_of_range) begin
            state_d = HALT;
            err_d   = 1'b1;
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            // The halt word is delivered but the PC parks on it.
            if (imem_rdata == HALT_WORD) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + 16'd2;
            end
        end
    end

    assign ifid_instr  = instr_q;
    assign ifid_pc     = ipc_q;
    assign ifid_valid  = valid_q;
    assign halted      = (state_q == HALT);
    assign fetch_err   = err_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int          DEPTH = 27;
    localparam logic [15:0] HALTW = 16'hEBCF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic        fetch_err;
    logic [15:0] fetch_count;

    logic [15:0] mem [DEPTH];

    int passes = 0;
    int total  = 0;

    // model state
    logic [15:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_halt, m_err;

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .IMEM_DEPTH(DEPTH),
        .HALT_WORD (HALTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 16'hDEAD;
        if (int'(imem_addr[15:1]) < DEPTH) begin
            imem_rdata = mem[int'(imem_addr[15:1])];
        end
    end

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        while (w == HALTW) w = 16'($urandom);
        return w;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd_word();
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Next state from the fetch rules, evaluated on the current inputs.
    task automatic model_step();
        int          idx;
        logic [15:0] w;
        idx = int'(m_pc) / 2;
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
            m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_cnt = 16'h0000;
        end else if (redirect) begin
            m_pc = redirect_pc - 16'(redirect_pc % 2);
            m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0; m_instr = 16'h0000;
        end else if (stall) begin
            m_halt = 1'b0;
        end else if (idx >= DEPTH) begin
            m_err = 1'b1; m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b1;
        end else begin
            w = mem[idx];
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (w == HALTW) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr,           m_pc);
        check({tag, ".instr"}, ifid_instr,          m_instr);
        check({tag, ".ipc"},   ifid_pc,             m_ipc);
        check({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, m_valid});
        check({tag, ".halt"},  {15'd0, halted},     {15'd0, m_halt});
        check({tag, ".err"},   {15'd0, fetch_err},  {15'd0, m_err});
        check({tag, ".cnt"},   fetch_count,         m_cnt);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0; m_cnt = 16'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
        fill_mem();

        // reset
        rst = 1'b1;
        tick("reset");
        check("reset.cnt0", fetch_count, 16'h0000);
        rst = 1'b0;

        // sequential fetch
        for (int i = 0; i < 4; i++) tick("seq");
        check("seq.cnt4", fetch_count, 16'd4);
        check("seq.pc6", ifid_pc, 16'h0006);
        check("seq.w3", ifid_instr, mem[3]);

        // stall at 0x0A
        tick("to0a");
        check("to0a.addr", imem_addr, 16'h000A);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.addr", imem_addr, 16'h000A);
        stall = 1'b0;
        tick("resume");
        check("resume.ipc", ifid_pc, 16'h000A);

        // redirect while stalled, odd target
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0021;
        tick("redir");
        check("redir.addr", imem_addr, 16'h0020);
        check("redir.valid", {15'd0, ifid_valid}, 16'h0000);
        stall = 1'b0; redirect = 1'b0;
        tick("redir_fetch");

        // halt word at 0x32
        mem[25] = HALTW;
        redirect = 1'b1; redirect_pc = 16'h0030;
        tick("to30");
        redirect = 1'b0;
        tick("f30");
        tick("f32");
        check("halt.instr", ifid_instr, HALTW);
        check("halt.flag", {15'd0, halted}, 16'h0001);
        check("halt.addr", imem_addr, 16'h0032);
        tick("bubble");
        stall = 1'b1;
        tick("bubble_st");
        stall = 1'b0;
        check("bubble.valid", {15'd0, ifid_valid}, 16'h0000);

        // halt squash
        redirect = 1'b1; redirect_pc = 16'h0018;
        tick("squash");
        check("squash.halt", {15'd0, halted}, 16'h0000);
        redirect = 1'b0;
        tick("squash_fetch");
        check("squash.ipc", ifid_pc, 16'h0018);

        // randomized traffic
        mem[7] = HALTW;
        for (int i = 0; i < 300; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 99) < 25);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = 16'($urandom_range(0, 16'h45));
            tick("rand");
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;

        // out-of-range then reset
        fill_mem();
        redirect = 1'b1; redirect_pc = 16'h0030;
        tick("rng_redir");
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) tick("rng_fetch");
        check("rng.addr36", imem_addr, 16'h0036);
        tick("rng_err");
        check("rng.err", {15'd0, fetch_err}, 16'h0001);
        check("rng.halt", {15'd0, halted}, 16'h0001);
        check("rng.valid", {15'd0, ifid_valid}, 16'h0000);
        tick("rng_hold");
        check("rng.addr", imem_addr, 16'h0036);
        rst = 1'b1;
        tick("rng_rst");
        check("rst.err", {15'd0, fetch_err}, 16'h0000);
        check("rst.addr", imem_addr, 16'h0000);
        check("rst.ipc", ifid_pc, 16'h0000);
        rst = 1'b0;
        tick("post_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter IMEM_DEPTH, default 27: number of 16-bit words in instruction memory.
REQ-003 Parameter HALT_WORD, default 16'hEBCF: instruction encoding that halts fetch.
REQ-004 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 stall  input  1: hold the PC and the IF/ID register this cycle.
REQ-007 redirect  input  1: taken branch or flush request from downstream.
REQ-008 redirect_pc  input  16: byte address of the redirect target.
REQ-009 imem_addr  output  16: byte address to instruction memory; SHALL equal pc combinationally.
REQ-010 imem_rdata  input  16: instruction word at imem_addr, valid in the same cycle.
REQ-011 ifid_instr  output  16: registered fetched instruction.
REQ-012 ifid_pc  output  16: registered byte address of ifid_instr.
REQ-013 ifid_valid  output  1: ifid_instr is a real instruction, not a bubble.
REQ-014 halted  output  1: high while in HALT.
REQ-015 fetch_err  output  1: sticky flag for an out-of-range fetch.
REQ-016 fetch_count  output  16: number of instructions delivered with valid=1, saturating.

Function
REQ-017 The FSM SHALL have two states. RUN: fetching. HALT: PC frozen and bubbles issued.
REQ-018 The PC SHALL be 16 bits and byte-addressed; the word index is pc[15:1].
REQ-019 Sequential increment SHALL be +2, wrapping from 16'hFFFE to 16'h0000.
REQ-020 Per-cycle priority SHALL be rst > redirect > HALT > stall > normal fetch.
REQ-021 Normal fetch (RUN, no stall, no redirect, in range):
  - ifid_instr <= imem_rdata
  - ifid_pc <= pc
  - ifid_valid <= 1
  - pc <= pc+2
  - fetch_count increments
  - Latency from imem_addr to ifid outputs SHALL be one cycle.
REQ-022 If the normal-fetch imem_rdata == HALT_WORD:
  - The halt word SHALL be latched as in REQ-021, valid=1.
  - pc SHALL hold, not increment.
  - The state SHALL go to HALT.
REQ-023 Stall in RUN: pc, ifid_instr, ifid_pc, ifid_valid and fetch_count SHALL all hold.
REQ-024 Redirect, in any state and regardless of stall:
  - pc <= {redirect_pc[15:1],1'b0}; bit 0 is forced to 0.
  - ifid_valid <= 0 and ifid_instr <= 16'h0000.
  - ifid_pc holds.
  - The state SHALL go to RUN; a wrong-path halt is thereby squashed.
REQ-025 HALT without redirect:
  - ifid_valid <= 0 and ifid_instr <= 16'h0000 every cycle.
  - pc and fetch_count hold.
  - stall is ignored.
REQ-026 Out-of-range fetch (RUN, pc[15:1] >= IMEM_DEPTH, no stall, no redirect):
  - fetch_err <= 1.
  - A bubble SHALL be issued.
  - The state SHALL go to HALT.
  - pc holds.
REQ-027 fetch_err SHALL clear only on rst.
REQ-028 fetch_count SHALL saturate at 16'hFFFF.
REQ-029 halted SHALL be registered and equal to (state == HALT).

Reset
REQ-030 On rst = 1 at a clock edge, the following SHALL load regardless of the other inputs:
  - pc <= RESET_PC
  - state <= RUN
  - ifid_instr <= 16'h0000, ifid_pc <= 16'h0000, ifid_valid <= 0
  - fetch_err <= 0, fetch_count <= 0
REQ-031 Reset asserted mid-stall, mid-redirect or in HALT SHALL behave identically to REQ-030.
REQ-032 The first fetch after reset SHALL occur at the first edge with rst = 0; imem_addr SHALL equal RESET_PC during that cycle.

Verification
REQ-033 Sequential fetch: reset, then 4 unstalled cycles with memory words W0..W3 -> ifid_pc = 0,2,4,6 in order, each valid=1, fetch_count = 4.
REQ-034 Stall: stall=1 for 3 cycles at pc=16'h0A -> ifid outputs and pc unchanged for 3 cycles; fetch resumes at 16'h0A.
REQ-035 Redirect: redirect=1 with redirect_pc=16'h0021 while stall=1 -> next cycle pc=16'h0020, ifid_valid=0, ifid_instr=16'h0000.
REQ-036 Halt: imem_rdata=16'hEBCF at pc=16'h32 -> ifid_instr=16'hEBCF with valid=1; halted=1; pc stays 16'h32; later cycles are bubbles.
REQ-037 Halt squash: in HALT, redirect with redirect_pc=16'h18 -> halted=0 and fetch resumes at 16'h18.
REQ-038 Range/reset: IMEM_DEPTH=27, pc reaches 16'h36 -> fetch_err=1 and halted=1; then rst=1 for 1 cycle -> all outputs back to their reset values.
